// File: rtl/ctrl_pipe_if.sv
// Signal bundle between the decode stage and the post-decode control pipeline.
// The decode side drives the bundle and controls; the pipe returns per-stage state.
interface ctrl_pipe_if #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 16
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // id_valid qualifies id_ctrl for the cycle it is high; there is no back-pressure,
  // so a valid bundle is taken at the edge unless stall, bubble or flush[0] say otherwise.
  logic [WIDTH-1:0]       id_ctrl;
  logic                   id_valid;
  logic                   bubble;
  logic                   stall;
  logic [DEPTH-1:0]       flush;
  logic [DEPTH*WIDTH-1:0] stage_ctrl;
  logic [DEPTH-1:0]       stage_valid;
  logic [OCC_W-1:0]       occupancy;

  modport master (
    output id_ctrl, id_valid, bubble, stall, flush,
    input  stage_ctrl, stage_valid, occupancy
  );

  modport slave (
    input  id_ctrl, id_valid, bubble, stall, flush,
    output stage_ctrl, stage_valid, occupancy
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Post-decode control pipeline: carries a control bundle through DEPTH stages with
// bubble/stall/flush handling, plus retire and stall statistics.
module ctrl_pipe #(
  parameter int               DEPTH     = 3,
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic        clk,
  input  logic        R,
  ctrl_pipe_if.slave  pif,
  output logic [15:0] retired_count,
  output logic [7:0]  stall_count
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
      $error("ctrl_pipe: DEPTH must be in 2..8");
    end
  endgenerate

  logic [DEPTH-1:0][WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [OCC_W-1:0]            occ;

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;

    // Stage 0: kill > hold > bubble/empty > load.
    if (pif.flush[0]) begin
      ctrl_d[0]  = NOP_VALUE;
      valid_d[0] = 1'b0;
    end else if (pif.stall) begin
      ctrl_d[0]  = ctrl_q[0];
      valid_d[0] = valid_q[0];
    end else if (pif.bubble || !pif.id_valid) begin
      ctrl_d[0]  = NOP_VALUE;
      valid_d[0] = 1'b0;
    end else begin
      ctrl_d[0]  = pif.id_ctrl;
      valid_d[0] = 1'b1;
    end

    // Stage 1 receives the load-use bubble while stage 0 is held.
    if (pif.flush[1] || pif.stall) begin
      ctrl_d[1]  = NOP_VALUE;
      valid_d[1] = 1'b0;
    end else begin
      ctrl_d[1]  = ctrl_q[0];
      valid_d[1] = valid_q[0];
    end

    for (int k = 2; k < DEPTH; k++) begin
      if (pif.flush[k]) begin
        ctrl_d[k]  = NOP_VALUE;
        valid_d[k] = 1'b0;
      end else begin
        ctrl_d[k]  = ctrl_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      ctrl_q  <= {DEPTH{NOP_VALUE}};
      valid_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      retired_count <= '0;
      stall_count   <= '0;
    end else begin
      if (valid_q[DEPTH-1] && !pif.flush[DEPTH-1]) retired_count <= retired_count + 16'd1;
      if (pif.stall && stall_count != 8'hFF)        stall_count   <= stall_count + 8'd1;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) occ = occ + OCC_W'(valid_q[k]);
  end

  assign pif.stage_ctrl  = ctrl_q;
  assign pif.stage_valid = valid_q;
  assign pif.occupancy   = occ;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed plus randomized bench for ctrl_pipe (DEPTH=3, WIDTH=16, NOP_VALUE=0),
// checked against a stage-list reference model.
module tb_ctrl_pipe;
  localparam int DEPTH = 3;
  localparam int WIDTH = 16;

  logic        clk;
  logic        R;
  logic [15:0] retired_count;
  logic [7:0]  stall_count;

  ctrl_pipe_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) pif ();

  ctrl_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NOP_VALUE('0)) dut (
    .clk           (clk),
    .R             (R),
    .pif           (pif),
    .retired_count (retired_count),
    .stall_count   (stall_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic [15:0] c;
  } stage_t;

  stage_t m [DEPTH];
  int     m_ret;
  int     m_stall;
  int     n_pass;
  int     n_checks;
  int     peak_occ;

  function automatic stage_t nop();
    stage_t s;
    s.v = 1'b0;
    s.c = 16'h0000;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m[k] = nop();
    m_ret   = 0;
    m_stall = 0;
  endtask

  // One rising edge as described in words: kill, hold, bubble, else move along.
  task automatic model_edge();
    stage_t nx [DEPTH];
    stage_t fresh;
    fresh.v = 1'b1;
    fresh.c = pif.id_ctrl;
    if (pif.flush[0])                        nx[0] = nop();
    else if (pif.stall)                      nx[0] = m[0];
    else if (pif.bubble || !pif.id_valid)    nx[0] = nop();
    else                                     nx[0] = fresh;
    nx[1] = (pif.flush[1] || pif.stall) ? nop() : m[0];
    for (int k = 2; k < DEPTH; k++) nx[k] = pif.flush[k] ? nop() : m[k-1];
    if (m[DEPTH-1].v && !pif.flush[DEPTH-1]) m_ret = (m_ret + 1) % 65536;
    if (pif.stall) m_stall = (m_stall >= 255) ? 255 : m_stall + 1;
    for (int k = 0; k < DEPTH; k++) m[k] = nx[k];
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int occ;
    occ = 0;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("%s ctrl%0d", tag, k), 64'(pif.stage_ctrl[k*WIDTH +: WIDTH]), 64'(m[k].c));
      check($sformatf("%s valid%0d", tag, k), 64'(pif.stage_valid[k]), 64'(m[k].v));
      occ += int'(m[k].v);
    end
    check({tag, " occ"},   64'(pif.occupancy), 64'(occ));
    check({tag, " ret"},   64'(retired_count), 64'(m_ret));
    check({tag, " stall"}, 64'(stall_count),   64'(m_stall));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] c, input logic v, input logic b,
                       input logic s, input logic [DEPTH-1:0] f);
    pif.id_ctrl  = c;
    pif.id_valid = v;
    pif.bubble   = b;
    pif.stall    = s;
    pif.flush    = f;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
    if (int'(pif.occupancy) > peak_occ) peak_occ = int'(pif.occupancy);
  endtask

  task automatic step_quiet();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_pass   = 0;
    n_checks = 0;
    peak_occ = 0;
    drive(16'h0000, 1'b0, 1'b0, 1'b0, '0);
    R = 1'b1;
    #1 R = 1'b0;
    model_reset();
    #2 check_all("reset_async");
    @(posedge clk); #1;
    check_all("reset_held");
    @(negedge clk) R = 1'b1;
    @(posedge clk); #1;

    // Streaming: 0x11,0x22,0x33 reach stage 2 on edges 3,4,5.
    peak_occ = 0;
    drive(16'h0011, 1'b1, 1'b0, 1'b0, '0); step("s_e1");
    drive(16'h0022, 1'b1, 1'b0, 1'b0, '0); step("s_e2");
    drive(16'h0033, 1'b1, 1'b0, 1'b0, '0); step("s_e3");
    check("s_stage2_e3", 64'(pif.stage_ctrl[2*WIDTH +: WIDTH]), 64'h0011);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, '0); step("s_e4");
    check("s_stage2_e4", 64'(pif.stage_ctrl[2*WIDTH +: WIDTH]), 64'h0022);
    step("s_e5");
    check("s_stage2_e5", 64'(pif.stage_ctrl[2*WIDTH +: WIDTH]), 64'h0033);
    step("s_e6");
    check("s_retired", 64'(retired_count), 64'd3);
    check("s_peak_occ", 64'(peak_occ), 64'd3);

    // Load-use stall for two cycles with 0xAA in stage 0.
    drive(16'h00AA, 1'b1, 1'b0, 1'b0, '0); step("st_load");
    drive(16'h00BB, 1'b1, 1'b0, 1'b1, '0); step("st_c1");
    check("st_hold1", 64'(pif.stage_ctrl[WIDTH-1:0]), 64'h00AA);
    step("st_c2");
    check("st_hold2", 64'(pif.stage_ctrl[WIDTH-1:0]), 64'h00AA);
    check("st_s1_bubble", 64'(pif.stage_valid[1]), 64'd0);
    check("st_count", 64'(stall_count), 64'd2);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, '0); step("st_r1");
    step("st_r2");
    check("st_late", 64'(pif.stage_ctrl[2*WIDTH +: WIDTH]), 64'h00AA);

    // Stall wins over bubble; flush[1] kills stage 1.
    drive(16'h0077, 1'b1, 1'b0, 1'b0, '0); step("bs_load");
    drive(16'h0055, 1'b1, 1'b1, 1'b1, '0); step("bs_both");
    check("bs_held", 64'(pif.stage_ctrl[WIDTH-1:0]), 64'h0077);
    drive(16'h0066, 1'b1, 1'b0, 1'b0, '0); step("fl_a");
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 3'b010); step("fl_kill");
    check("fl_s1_dead", 64'(pif.stage_valid[1]), 64'd0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, '0); step("fl_d1");
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 3'b100); step("fl_d2");
    step("fl_d3");
    // Stall and flush[0] together: kill wins.
    drive(16'h0099, 1'b1, 1'b0, 1'b0, '0); step("sf_load");
    drive(16'h0000, 1'b1, 1'b0, 1'b1, 3'b001); step("sf_kill");
    check("sf_s0_dead", 64'(pif.stage_valid[0]), 64'd0);

    // Stall counter saturation.
    drive(16'h0000, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 300; i++) step_quiet();
    check_all("sat");
    check("sat_255", 64'(stall_count), 64'd255);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, '0); step("sat_hold");

    // Retire counter wrap: stream until the model sits at 0xFFFE.
    for (int i = 0; i < 70000 && m_ret != 16'hFFFE; i++) begin
      drive(16'($urandom), 1'b1, 1'b0, 1'b0, '0);
      step_quiet();
    end
    check_all("wrap_pre");
    drive(16'h1234, 1'b1, 1'b0, 1'b0, '0); step("wrap_ffff");
    step("wrap_0000");
    check("wrap_zero", 64'(retired_count), 64'h0000);

    // Asynchronous reset with a full pipeline, between edges.
    check("full_occ", 64'(pif.occupancy), 64'd3);
    #2 R = 1'b0;
    model_reset();
    #1 check_all("mid_reset");
    R = 1'b1;
    drive(16'h0042, 1'b1, 1'b0, 1'b0, '0); step("post_reset");
    check("post_reset_s0", 64'(pif.stage_ctrl[WIDTH-1:0]), 64'h0042);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(16'($urandom),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000);
      step($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL take parameter DEPTH, default 3, number of post-decode stages (EX, MEM, WB); legal range 2..8.
REQ-002 The block SHALL take parameter WIDTH, default 16, width of the control bundle carried per stage.
REQ-003 The block SHALL take parameter NOP_VALUE, default 0, control bundle loaded on bubble, flush or reset.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 R  input  1  asynchronous active-low reset.
REQ-007 id_ctrl  input  WIDTH  decoded control bundle from ID.
REQ-008 id_valid  input  1  id_ctrl holds a real instruction.
REQ-009 bubble  input  1  force NOP into stage 0 (CU-mux select).
REQ-010 stall  input  1  load-use stall: hold stage 0, inject bubble into stage 1.
REQ-011 flush  input  DEPTH  per-stage kill, bit k kills stage k.
REQ-012 stage_ctrl  output  DEPTH*WIDTH  registered bundle of stage k at bits [k*WIDTH +: WIDTH].
REQ-013 stage_valid  output  DEPTH  registered valid bit per stage.
REQ-014 occupancy  output  $clog2(DEPTH+1)  combinational count of set stage_valid bits.
REQ-015 retired_count  output  16  instructions leaving the last stage, wraps.
REQ-016 stall_count  output  8  stalled cycles, saturating.

Function
REQ-017 Stage 0 at each rising edge SHALL apply priority flush[0] > stall > (bubble or !id_valid) > load: kill loads NOP_VALUE/valid 0; stall holds; bubble or !id_valid loads NOP_VALUE/valid 0; load takes id_ctrl/valid 1.
REQ-018 Stage 1 at each rising edge SHALL apply priority flush[1] > stall > advance: kill and stall load NOP_VALUE/valid 0; advance copies stage 0 bundle and valid.
REQ-019 Stage k, k>=2, SHALL load NOP_VALUE/valid 0 if flush[k], else copy stage k-1 bundle and valid.
REQ-020 Every stage SHALL update from the pre-edge values of its predecessor, with single-cycle latency per stage; id_ctrl reaches stage DEPTH-1 after DEPTH edges absent stall, bubble and flush.
REQ-021 A stage with valid 0 SHALL always carry exactly NOP_VALUE.
REQ-022 Simultaneous stall and bubble SHALL behave as stall; simultaneous stall and flush[0] SHALL kill stage 0.
REQ-023 retired_count SHALL increment by 1 at each edge where stage_valid[DEPTH-1] is 1 and flush[DEPTH-1] is 0, wrapping 0xFFFF to 0x0000.
REQ-024 stall_count SHALL increment at each edge with stall 1, holding at 255.
REQ-025 occupancy SHALL equal the popcount of stage_valid with no added latency.
REQ-026 A parameter DEPTH outside 2..8 SHALL produce an elaboration-time error.

Reset
REQ-027 R low SHALL immediately, without waiting for clk, force every stage to NOP_VALUE with valid 0, retired_count to 0 and stall_count to 0; occupancy then reads 0.
REQ-028 R asserted mid-operation SHALL discard all in-flight bundles; after R returns high, the first edge behaves per REQ-017..019.

Verification (DEPTH=3, WIDTH=16, NOP_VALUE=0)
REQ-029 Reset, then stream id_ctrl 0x0011, 0x0022, 0x0033 with id_valid 1 -> stage 2 shows 0x0011, 0x0022, 0x0033 on edges 3, 4, 5; retired_count 3; occupancy peaks at 3.
REQ-030 Stage 0 holds 0x00AA, stall 1 for 2 cycles -> stage 0 stays 0x00AA; stage 1 is 0x0000/valid 0 both cycles; stall_count 2; 0x00AA reaches stage 2 two edges late.
REQ-031 bubble and stall both 1 with id_ctrl 0x0055 -> stage 0 held, 0x0055 not captured; flush=3'b010 with stage 1 valid -> stage 1 killed and retired_count does not count it.
REQ-032 Hold stall 1 for 300 cycles -> stall_count reaches 255 and stays; preload retired_count 0xFFFE via 2 extra retires -> counter reads 0x0000.
REQ-033 Pipeline full (occupancy 3), drive R low between edges -> all outputs zero before next edge; release R, next edge loads id_ctrl normally.
